// File: rtl/gnr_ctrl_pkg.sv
// ---------------------------------------------------------------
// gnr_ctrl_pkg : shared types and sizes for the GRN attractor search
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

package gnr_ctrl_pkg;

  localparam int GNR_NUM_NODES = 188;
  localparam int GNR_CNT_W     = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_RUN    = 2'd2,
    ST_REPORT = 2'd3
  } gnr_ctrl_state_t;

endpackage

`default_nettype wire

// File: rtl/gnr_attractor_ctrl.sv
// ---------------------------------------------------------------
// gnr_attractor_ctrl : per-seed tortoise/hare attractor search sequencer
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module gnr_attractor_ctrl
  import gnr_ctrl_pkg::*;
#(
  parameter int NUM_NODES = GNR_NUM_NODES,
  parameter int CNT_W     = GNR_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [NUM_NODES-1:0] seed_base,
  input  logic [CNT_W-1:0]     num_seeds,
  input  logic [CNT_W-1:0]     max_steps,
  input  logic [NUM_NODES-1:0] s0,
  input  logic [NUM_NODES-1:0] s1,
  output logic                 reset_nos,
  output logic [NUM_NODES-1:0] init_state,
  output logic                 start_s0,
  output logic                 start_s1,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [NUM_NODES-1:0] res_seed,
  output logic [CNT_W-1:0]     res_steps,
  output logic                 res_timeout,
  output logic                 busy,
  output logic                 done
);

  gnr_ctrl_state_t        state_q, state_d;
  logic [NUM_NODES-1:0]   seed_q, seed_d;
  logic [CNT_W-1:0]       remain_q, remain_d;
  logic [CNT_W-1:0]       max_q, max_d;
  logic [CNT_W-1:0]       k_q, k_d;
  logic [NUM_NODES-1:0]   res_seed_q, res_seed_d;
  logic [CNT_W-1:0]       res_steps_q, res_steps_d;
  logic                   res_timeout_q, res_timeout_d;
  logic                   done_q, done_d;

  logic                   in_run;
  logic                   vec_eq;
  logic                   hit;
  logic                   tmo;
  logic                   step;

  // Odd k is never compared: at k=1 both vectors hold F(seed), a false match.
  assign in_run = (state_q == ST_RUN);
  assign vec_eq = (s0 == s1);
  assign hit    = in_run && !k_q[0] && (k_q != '0) && vec_eq;
  assign tmo    = in_run && !hit && (k_q == max_q);
  assign step   = in_run && !hit && !tmo;

  assign start_s0    = step;
  assign start_s1    = step;
  assign res_valid   = (state_q == ST_REPORT);
  assign busy        = (state_q != ST_IDLE);
  assign done        = done_q;
  assign res_seed    = res_seed_q;
  assign res_steps   = res_steps_q;
  assign res_timeout = res_timeout_q;

  always_comb begin
    state_d       = state_q;
    seed_d        = seed_q;
    remain_d      = remain_q;
    max_d         = max_q;
    k_d           = k_q;
    res_seed_d    = res_seed_q;
    res_steps_d   = res_steps_q;
    res_timeout_d = res_timeout_q;
    done_d        = 1'b0;
    reset_nos     = 1'b0;
    init_state    = '0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          seed_d   = seed_base;
          remain_d = num_seeds;
          max_d    = max_steps;
          if (num_seeds == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        reset_nos  = 1'b1;
        init_state = seed_q;
        k_d        = '0;
        state_d    = ST_RUN;
      end
      ST_RUN: begin
        // step is only possible while k_q < max_q, so k never passes the budget
        if (step) begin
          k_d = k_q + CNT_W'(1);
        end
        if (hit || tmo) begin
          res_seed_d    = seed_q;
          res_steps_d   = k_q;
          res_timeout_d = tmo;
          state_d       = ST_REPORT;
        end
      end
      ST_REPORT: begin
        if (res_ready) begin
          remain_d = remain_q - CNT_W'(1);
          if (remain_q == CNT_W'(1)) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            seed_d  = seed_q + NUM_NODES'(1);
            state_d = ST_LOAD;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      seed_q        <= '0;
      remain_q      <= '0;
      max_q         <= '0;
      k_q           <= '0;
      res_seed_q    <= '0;
      res_steps_q   <= '0;
      res_timeout_q <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      seed_q        <= seed_d;
      remain_q      <= remain_d;
      max_q         <= max_d;
      k_q           <= k_d;
      res_seed_q    <= res_seed_d;
      res_steps_q   <= res_steps_d;
      res_timeout_q <= res_timeout_d;
      done_q        <= done_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_gnr_attractor_ctrl.sv
// ---------------------------------------------------------------
// tb_gnr_attractor_ctrl : randomized self-checking bench with node-array model
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module tb_gnr_attractor_ctrl;

  localparam int N  = 188;
  localparam int CW = 32;

  logic          clk;
  logic          rst;
  logic          start;
  logic [N-1:0]  seed_base;
  logic [CW-1:0] num_seeds;
  logic [CW-1:0] max_steps;
  logic [N-1:0]  s0;
  logic [N-1:0]  s1;
  logic          reset_nos;
  logic [N-1:0]  init_state;
  logic          start_s0;
  logic          start_s1;
  logic          res_valid;
  logic          res_ready;
  logic [N-1:0]  res_seed;
  logic [CW-1:0] res_steps;
  logic          res_timeout;
  logic          busy;
  logic          done;

  gnr_attractor_ctrl #(.NUM_NODES(N), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .seed_base(seed_base),
    .num_seeds(num_seeds), .max_steps(max_steps), .s0(s0), .s1(s1),
    .reset_nos(reset_nos), .init_state(init_state), .start_s0(start_s0),
    .start_s1(start_s1), .res_valid(res_valid), .res_ready(res_ready),
    .res_seed(res_seed), .res_steps(res_steps), .res_timeout(res_timeout),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: condition not met", name);
  endtask

  // Network map: identity, or a rho shape on the low 16 bits
  // (tail f_L, cycle f_P) with the upper bits carried through.
  bit f_ident = 1'b1;
  int f_L = 0;
  int f_P = 1;

  function automatic logic [N-1:0] f_next(input logic [N-1:0] x);
    logic [N-1:0] y;
    logic [15:0]  lo;
    y = x;
    if (f_ident) return x;
    lo = x[15:0];
    if (int'(lo) < f_L + f_P - 1) lo = lo + 16'd1;
    else lo = 16'(f_L);
    y[15:0] = lo;
    return y;
  endfunction

  // Smallest even k in (0, max] with F^(k/2)(seed) == F^k(seed), else a timeout at max.
  function automatic void model_run(input logic [N-1:0] seed, input int unsigned maxs,
                                    output int unsigned steps, output bit tmo);
    logic [N-1:0] t;
    logic [N-1:0] h;
    t = seed;
    h = seed;
    for (int unsigned j = 1; 2 * j <= maxs; j++) begin
      t = f_next(t);
      h = f_next(f_next(h));
      if (t == h) begin
        steps = 2 * j;
        tmo   = 1'b0;
        return;
      end
    end
    steps = maxs;
    tmo   = 1'b1;
  endfunction

  // Behavioural node array driven by the controller.
  logic [N-1:0] arr_s0, arr_s1;
  logic         arr_pass;
  assign s0 = arr_s0;
  assign s1 = arr_s1;
  always @(posedge clk) begin
    if (reset_nos) begin
      arr_s0   <= init_state;
      arr_s1   <= init_state;
      arr_pass <= 1'b1;
    end else begin
      if (start_s1) arr_s1 <= f_next(arr_s1);
      if (start_s0) begin
        if (arr_pass) arr_s0 <= f_next(arr_s0);
        arr_pass <= !arr_pass;
      end
    end
  end

  // 0: random ready, 1: always ready, 2: held by the test
  int ready_ctl = 1;
  always @(posedge clk) begin
    #1;
    if (ready_ctl == 0) res_ready = 1'($urandom_range(0, 1));
    else if (ready_ctl == 1) res_ready = 1'b1;
  end

  typedef struct {
    logic [N-1:0] seed;
    int unsigned  steps;
    bit           tmo;
  } exp_t;

  exp_t         q[$];
  exp_t         m_e;
  bit           m_idle;
  bit           done_pend = 1'b0;
  int           done_count = 0;
  int           hs_count = 0;
  int           rn_count = 0;
  int           pulses = 0;
  int           last_pulses = 0;
  logic [N-1:0] last_seed = '0;
  int unsigned  last_steps = 0;
  bit           last_tmo = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_res_valid", res_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_reset_nos", reset_nos, 0);
      chk("rst_start_s1", start_s1, 0);
      chk("rst_init_state", init_state, 0);
      chk("rst_res_seed", res_seed, 0);
      chk("rst_res_steps", res_steps, 0);
      chk("rst_res_timeout", res_timeout, 0);
      q.delete();
      done_pend = 1'b0;
      pulses = 0;
    end else begin
      m_idle = (q.size() == 0);
      chk("busy", busy, !m_idle);
      chk("done", done, done_pend);
      if (done) done_count++;
      done_pend = 1'b0;
      chk("step_enables_equal", start_s0, start_s1);
      if (reset_nos) begin
        rn_count++;
        pulses = 0;
        if (m_idle) fail_now("reset_nos_while_idle");
        else chk("init_state", init_state, q[0].seed);
      end
      if (start_s1) pulses++;
      if (res_valid) begin
        if (m_idle) fail_now("res_valid_spurious");
        else begin
          chk("res_seed", res_seed, q[0].seed);
          chk("res_steps", res_steps, q[0].steps);
          chk("res_timeout", res_timeout, q[0].tmo);
          if (res_ready) begin
            chk("step_pulses", pulses, q[0].steps);
            last_seed   = res_seed;
            last_steps  = res_steps;
            last_tmo    = res_timeout;
            last_pulses = pulses;
            hs_count++;
            void'(q.pop_front());
            done_pend = (q.size() == 0);
          end
        end
      end
      if (start && m_idle) begin
        if (num_seeds == '0) done_pend = 1'b1;
        for (int i = 0; i < int'(num_seeds); i++) begin
          m_e.seed = seed_base + N'(i);
          model_run(m_e.seed, max_steps, m_e.steps, m_e.tmo);
          q.push_back(m_e);
        end
      end
    end
  end

  function automatic logic [N-1:0] rand_vec();
    logic [191:0] v;
    v = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return v[N-1:0];
  endfunction

  task automatic apply_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic drive_start(input logic [N-1:0] base, input int num, input int maxs);
    @(posedge clk);
    #1;
    seed_base = base;
    num_seeds = CW'(num);
    max_steps = CW'(maxs);
    start     = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int d0;
    d0 = done_count;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      #1;
      if (done_count != d0) return;
    end
    fail_now("batch_done_timeout");
    apply_reset();
  endtask

  task automatic wait_rn(input int budget);
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (reset_nos) return;
    end
    fail_now("reset_nos_timeout");
  endtask

  task automatic run_batch(input logic [N-1:0] base, input int num, input int maxs);
    drive_start(base, num, maxs);
    wait_done((num + 1) * (maxs + 40) + 100);
  endtask

  int unsigned  lit_steps;
  bit           lit_tmo;
  int           vc, rc, d0, r0, h0;
  logic [N-1:0] base_v, snap_seed;
  logic [CW-1:0] snap_steps;

  initial begin
    rst = 1'b0; start = 1'b0; seed_base = '0; num_seeds = '0; max_steps = '0;
    res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // Fixed point: result at cycle 5 with two steps
    f_ident = 1'b1;
    model_run(N'(5), 100, lit_steps, lit_tmo);
    chk("model_fixed_steps", lit_steps, 2);
    chk("model_fixed_tmo", lit_tmo, 0);
    d0 = done_count;
    @(posedge clk);
    #1 seed_base = N'(5); num_seeds = 1; max_steps = 100; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    vc = 0; rc = 0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (reset_nos && rc == 0) rc = n;
      if (res_valid && vc == 0) vc = n;
    end
    chk("fp_load_cycle", rc, 1);
    chk("fp_valid_cycle", vc, 5);
    chk("fp_res_seed", last_seed, 5);
    chk("fp_res_steps", last_steps, 2);
    chk("fp_res_timeout", last_tmo, 0);
    chk("fp_done_count", done_count - d0, 1);

    // Period-3 cycle after a 4-step transient
    f_ident = 1'b0; f_L = 4; f_P = 3;
    model_run('0, 100, lit_steps, lit_tmo);
    chk("model_rho_steps", lit_steps, 12);
    run_batch('0, 1, 100);
    chk("rho_res_steps", last_steps, 12);
    chk("rho_res_timeout", last_tmo, 0);

    // Timeout on a period-50 cycle
    f_L = 0; f_P = 50;
    model_run('0, 10, lit_steps, lit_tmo);
    chk("model_tmo_flag", lit_tmo, 1);
    run_batch('0, 1, 10);
    chk("tmo_res_steps", last_steps, 10);
    chk("tmo_res_timeout", last_tmo, 1);
    chk("tmo_step_pulses", last_pulses, 10);

    // Backpressure on the second of three results
    f_L = 1; f_P = 2;
    base_v = rand_vec();
    base_v[15:0] = 16'd0;
    ready_ctl = 2;
    res_ready = 1'b1;
    d0 = done_count;
    h0 = hs_count;
    drive_start(base_v, 3, 40);
    for (int c = 0; c < 200 && hs_count == h0; c++) @(negedge clk);
    @(posedge clk);
    #1 res_ready = 1'b0;
    for (int c = 0; c < 200 && !res_valid; c++) @(negedge clk);
    snap_seed = res_seed;
    snap_steps = res_steps;
    repeat (7) begin
      @(negedge clk);
      chk("bp_valid_held", res_valid, 1);
      chk("bp_seed_stable", res_seed, snap_seed);
      chk("bp_steps_stable", res_steps, snap_steps);
    end
    chk("bp_second_seed", snap_seed, base_v + N'(1));
    @(posedge clk);
    #1 res_ready = 1'b1;
    wait_done(400);
    repeat (4) @(posedge clk);
    chk("bp_last_seed", last_seed, base_v + N'(2));
    chk("bp_done_once", done_count - d0, 1);
    ready_ctl = 1;

    // Reset in the middle of RUN at k = 3
    f_L = 0; f_P = 50;
    d0 = done_count;
    drive_start(rand_vec(), 2, 40);
    wait_rn(50);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_start_s1", start_s1, 0);
    chk("mid_rst_res_valid", res_valid, 0);
    chk("mid_rst_init_state", init_state, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    chk("mid_rst_no_done", done_count - d0, 0);
    f_L = 2; f_P = 3;
    base_v = rand_vec();
    base_v[15:0] = 16'd0;
    run_batch(base_v, 2, 30);
    chk("post_rst_last_seed", last_seed, base_v + N'(1));

    // start while busy is ignored
    f_L = 0; f_P = 50;
    drive_start(rand_vec(), 1, 30);
    wait_rn(50);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 seed_base = rand_vec(); num_seeds = 3; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(200);

    // num_seeds = 0: done one cycle after start, no load
    r0 = rn_count;
    @(posedge clk);
    #1 num_seeds = 0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("zero_done_pulse", done, 1);
    @(negedge clk);
    chk("zero_done_low", done, 0);
    chk("zero_no_reset_nos", rn_count - r0, 0);

    // Seed counter wraps modulo 2^N
    f_ident = 1'b1;
    run_batch('1, 3, 20);
    chk("wrap_last_seed", last_seed, N'(1));

    // Randomized batches with random backpressure
    ready_ctl = 0;
    for (int b = 0; b < 30; b++) begin
      f_ident = ($urandom_range(0, 4) == 0);
      f_L = $urandom_range(0, 6);
      f_P = ($urandom_range(0, 3) == 0) ? 50 : $urandom_range(1, 6);
      base_v = rand_vec();
      base_v[15:0] = 16'($urandom_range(0, 10));
      run_batch(base_v, $urandom_range(1, 4), $urandom_range(0, 40));
    end

    repeat (5) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/gnr_attractor_ctrl.md
# gnr_attractor_ctrl

Sequencer that drives the GRN node array (one tortoise/hare state pair per node) and finds the attractor reached from each initial network state. It sits directly upstream of the node array. For each seed it:
- loads the seed through `reset_nos` and `init_state`;
- clocks the array with `start_s0` and `start_s1`;
- compares the tortoise vector against the hare vector until they match or a step budget expires;
- reports one result per seed over a valid/ready port.

## Interface

Parameters:
- `NUM_NODES`, default 188: network size and width of every state vector.
- `CNT_W`, default 32: width of the step and seed counters.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle request to begin a batch. Sampled only in IDLE.
- `seed_base` in NUM_NODES: first initial state. Sampled on an accepted `start`.
- `num_seeds` in CNT_W: number of seeds to run. Sampled on an accepted `start`.
- `max_steps` in CNT_W: hare step budget per seed. Sampled on an accepted `start`.
- `s0` in NUM_NODES: concatenated tortoise states from the node array.
- `s1` in NUM_NODES: concatenated hare states from the node array.
- `reset_nos` out 1: load `init_state` into all nodes and arm the tortoise `pass` flag.
- `init_state` out NUM_NODES: per-node initial value.
- `start_s0` out 1: step enable for the tortoise.
- `start_s1` out 1: step enable for the hare.
- `res_valid` out 1: result is available.
- `res_ready` in 1: consumer accepts the result.
- `res_seed` out NUM_NODES: seed that produced this result.
- `res_steps` out CNT_W: hare steps taken when the run stopped.
- `res_timeout` out 1: run stopped on the budget, not on a match.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse after the last result is accepted.

## Operation

States: IDLE, LOAD, RUN, REPORT.

- **IDLE**
  - `start` latches `seed` = `seed_base`, `remain` = `num_seeds` and `max_steps`.
  - If `num_seeds` == 0: pulse `done` and stay in IDLE. Otherwise go to LOAD.
  - `start` is ignored in every other state.
- **LOAD** (exactly one cycle)
  - `reset_nos` = 1 and `init_state` = `seed`.
  - Clear step counter `k`, then go to RUN.
- **RUN**
  - Define `hit` = (`k` even) && (`k` != 0) && (`s0` == `s1`).
  - Define `tmo` = !`hit` && (`k` == `max_steps`).
  - `start_s0` = `start_s1` = (state == RUN) && !`hit` && !`tmo`. These are combinational, so no step is applied on the stop cycle.
  - On each step cycle, `k` increments by 1.
  - The node array advances the hare every step and the tortoise every other step. After `k` steps (`k` even), `s1` = F^k(seed) and `s0` = F^(k/2)(seed).
  - The odd-`k` compare is excluded because at `k`=1 both vectors equal F(seed), a false match.
  - On `hit` or `tmo`: register `res_seed` = `seed`, `res_steps` = `k` and `res_timeout` = `tmo`, then go to REPORT.
- **REPORT**
  - `res_valid` = 1 and the result fields are held stable until `res_valid` && `res_ready`.
  - On handshake: decrement `remain`.
  - If `remain` is now 0: pulse `done` next cycle and go to IDLE.
  - Otherwise: `seed` = `seed` + 1 (NUM_NODES-bit, wraps modulo 2^NUM_NODES) and go to LOAD.
- **Width and counting rules**
  - `k` saturates at `max_steps` and never wraps.
  - `max_steps` == 0 gives an immediate timeout with `res_steps` = 0.
  - Odd `max_steps` still compares only at even `k`.

## Timing

- **Reset values:** state IDLE; all outputs 0, including `init_state`, `res_*`, `busy` and `done`. Internal counters are cleared.
- **Reset mid-operation:** the block returns to IDLE at once. Any pending result is discarded and no `done` pulse is issued.
- **Latency, fixed-point seed** (F(x) = x), `start` sampled at edge 0:
  - cycle 1: LOAD;
  - cycles 2–3: RUN steps, `k` = 0 then 1;
  - cycle 4: `k` = 2 and `hit`, so no steps are issued;
  - cycle 5: `res_valid` = 1 with `res_steps` = 2.
- **Seed-to-seed overhead:** 1 LOAD cycle + 1 stop cycle + REPORT cycles, with no bubble when `res_ready` is held high.
- **Simultaneous `hit` and `k` == `max_steps`:** `hit` wins and `res_timeout` = 0.
- **`res_ready` before `res_valid`:** has no effect.

## Structure

- Shared package `gnr_ctrl_pkg` holds:
  - state enum `gnr_ctrl_state_t` (IDLE/LOAD/RUN/REPORT);
  - default `CNT_W`;
  - `GNR_NUM_NODES`, shared with the node-array wrapper.
- No sub-module is needed. The FSM, counters, NUM_NODES-wide equality compare and result register are all inside this block.
- If timing on the wide compare fails, it splits out as `gnr_vec_eq`, a registered reduction tree. That adds one cycle, and the stop decision then uses the previous cycle's `k`.

## Test plan

- **Fixed point:** behavioural array F(x) = x, `seed_base` = 5, `num_seeds` = 1, `max_steps` = 100 → one result with `res_seed` = 5, `res_steps` = 2, `res_timeout` = 0, `res_valid` at cycle 5, then a `done` pulse.
- **Period-3 cycle after a 4-step transient**, `max_steps` = 100 → `res_steps` is the first even `k` with F^(k/2) = F^k, checked against the model.
- **Timeout:** F has period 50, `max_steps` = 10 → `res_timeout` = 1, `res_steps` = 10, and exactly 10 `start_s1` pulses are issued.
- **Backpressure:** `num_seeds` = 3, `res_ready` held low for 7 cycles on the second result → `res_*` stay stable, seeds are reported as base, base+1, base+2, and `done` fires once.
- **Reset mid-RUN:** assert `rst` low at `k` = 3 → all outputs return to 0 immediately. A new `start` then runs cleanly from `seed_base`.
- **`start` while busy, and `num_seeds` = 0:** `start` pulsed during RUN has no effect. `num_seeds` = 0 gives `done` one cycle after `start`, with no `reset_nos` pulse.
